// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch control front-end.
//   sw_state_e      : IDLE / RUN / PAUSE state encoding of the control FSM
//   TICK_DIV_DEF    : default CLK cycles per 1/100 s EN tick (50 MHz -> 100 Hz)
//   DEB_CYCLES_DEF  : default debounce stability window (5 ms at 50 MHz)
//   cnt_width()     : bits needed to hold an unsigned value 0..max_val
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int TICK_DIV_DEF   = 500000;
    localparam int DEB_CYCLES_DEF = 250000;

    // Minimum counter width able to represent 0..max_val (at least 1 bit).
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stopwatch_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw, asynchronous, active-high push-button:
// 2-FF synchroniser -> stability-window debouncer -> rising-edge detector.
//
// Ports:
//   CLK      in   clock
//   RST      in   synchronous, active-high reset (clears every flop)
//   BTN_RAW  in   raw button level, asynchronous to CLK
//   LEVEL    out  debounced button level
//   PRESS    out  one-cycle pulse on each debounced press (releases give none)
//
// The debounced level only changes after the synchronised input has disagreed
// with it on DEB_CYCLES consecutive clock edges; any agreement restarts the
// window, so glitches shorter than DEB_CYCLES cycles never reach LEVEL.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEB_CYCLES = stopwatch_pkg::DEB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_RAW,
    output logic LEVEL,
    output logic PRESS
);
    import stopwatch_pkg::*;

    localparam int              CW     = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   C_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = BTN_RAW;
        sync2_d      = sync1_q;
        level_d      = level_q;
        level_prev_d = level_q;
        cnt_d        = '0;
        if (sync2_q != level_q) begin
            // The edge that would take the count to DEB_CYCLES is the one
            // that flips the level, so the count never exceeds DEB_CYCLES-1.
            if (cnt_q == C_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

    assign LEVEL = level_q;
    assign PRESS = level_q & ~level_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control front-end for the stopwatch: conditions the three push-buttons,
// runs the IDLE/RUN/PAUSE state machine, generates the 1/100 s time-base and
// drives the strobes consumed by the downstream BCD counter chain.
//
// Ports:
//   CLK      in   clock
//   RST      in   synchronous, active-high reset
//   BTN_SS   in   raw start/stop button (async, active-high)
//   BTN_CLR  in   raw clear button (async, active-high)
//   BTN_INC  in   raw manual-increment button (async, active-high)
//   EN       out  count-enable tick, 1-cycle pulse every TICK_DIV cycles in RUN
//   INC      out  manual increment, 1-cycle pulse
//   CLR      out  clear, 1-cycle pulse
//   RUN      out  high while the FSM is in RUN (LED)
//
// All outputs are registered. EN is only ever produced from RUN while INC and
// CLR are only produced from IDLE/PAUSE, so the three strobes can never
// coincide. Simultaneous presses resolve CLR > SS > INC.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV   = stopwatch_pkg::TICK_DIV_DEF,
    parameter int DEB_CYCLES = stopwatch_pkg::DEB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_SS,
    input  logic BTN_CLR,
    input  logic BTN_INC,
    output logic EN,
    output logic INC,
    output logic CLR,
    output logic RUN
);
    import stopwatch_pkg::*;

    // The RUN port shadows the package literal, so states are named locally.
    localparam sw_state_e ST_IDLE  = stopwatch_pkg::IDLE;
    localparam sw_state_e ST_RUN   = stopwatch_pkg::RUN;
    localparam sw_state_e ST_PAUSE = stopwatch_pkg::PAUSE;

    localparam int            PW         = cnt_width(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic       p_ss, p_clr, p_inc;
    // Debounced levels are not needed by the FSM, which acts on presses only.
    logic [2:0] lvl_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .CLK     (CLK),
        .RST     (RST),
        .BTN_RAW (BTN_SS),
        .LEVEL   (lvl_unused[0]),
        .PRESS   (p_ss)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .CLK     (CLK),
        .RST     (RST),
        .BTN_RAW (BTN_CLR),
        .LEVEL   (lvl_unused[1]),
        .PRESS   (p_clr)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .CLK     (CLK),
        .RST     (RST),
        .BTN_RAW (BTN_INC),
        .LEVEL   (lvl_unused[2]),
        .PRESS   (p_inc)
    );

    // ------------------------------------------------------------------
    // FSM, prescaler and registered strobes
    // ------------------------------------------------------------------
    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          en_q, en_d;
    logic          inc_q, inc_d;
    logic          clr_q, clr_d;
    logic          run_q, run_d;

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        en_d    = 1'b0;
        inc_d   = 1'b0;
        clr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (p_clr) begin
                    clr_d = 1'b1;
                end else if (p_ss) begin
                    state_d = ST_RUN;
                end else if (p_inc) begin
                    inc_d   = 1'b1;
                    state_d = ST_PAUSE;
                end
            end
            ST_RUN: begin
                // Clear and increment are deliberately inert while counting.
                if (p_ss) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (p_clr) begin
                    clr_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (p_ss) begin
                    state_d = ST_RUN;
                end else if (p_inc) begin
                    inc_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The prescaler runs from 0 on entry to RUN, so the first EN comes
        // a full TICK_DIV cycles later. A wrap coinciding with a pause still
        // issues its EN; the partial period is then discarded.
        if (state_q == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                en_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (state_d != ST_RUN) begin
            presc_d = '0;
        end

        run_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            en_q    <= 1'b0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            en_q    <= en_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
            run_q   <= run_d;
        end
    end

    assign EN  = en_q;
    assign INC = inc_q;
    assign CLR = clr_q;
    assign RUN = run_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl with TICK_DIV=5, DEB_CYCLES=4.
// A behavioural model (sample history windows, run-age arithmetic) predicts
// every output each cycle; directed phases add pulse-count and latency checks.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 5;
    localparam int DEB      = 4;

    localparam logic [2:0] B_SS  = 3'b001;
    localparam logic [2:0] B_CLR = 3'b010;
    localparam logic [2:0] B_INC = 3'b100;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN_SS = 1'b0, BTN_CLR = 1'b0, BTN_INC = 1'b0;
    logic EN, INC, CLR, RUN;

    always #5 CLK = ~CLK;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BTN_SS  (BTN_SS),
        .BTN_CLR (BTN_CLR),
        .BTN_INC (BTN_INC),
        .EN      (EN),
        .INC     (INC),
        .CLR     (CLR),
        .RUN     (RUN)
    );

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    int         m_state, m_next, run_age;
    logic       m_en, m_inc, m_clr, m_run;
    logic [1:0] pipe   [3];   // [1] is the sample the debouncer sees next
    logic       lvl    [3];
    logic       press  [3];
    logic [15:0] hist  [3];   // samples seen since the last level change
    int         hist_len [3];
    logic [2:0] raw;
    logic       seen;
    logic [DEB-1:0] want;

    always @(posedge CLK) begin
        if (RST) begin
            m_state = M_IDLE;
            run_age = 0;
            m_en = 1'b0; m_inc = 1'b0; m_clr = 1'b0; m_run = 1'b0;
            for (int b = 0; b < 3; b++) begin
                pipe[b] = 2'b00; lvl[b] = 1'b0; press[b] = 1'b0;
                hist[b] = '0; hist_len[b] = 0;
            end
        end else begin
            raw = {BTN_INC, BTN_CLR, BTN_SS};
            m_en = 1'b0; m_inc = 1'b0; m_clr = 1'b0;
            m_next = m_state;
            // Time-base: EN after every TICK_DIV-th consecutive cycle in RUN.
            if (m_state == M_RUN) begin
                run_age++;
                if (run_age % TICK_DIV == 0) m_en = 1'b1;
            end
            if (m_state == M_IDLE) begin
                if (press[1]) m_clr = 1'b1;
                else if (press[0]) m_next = M_RUN;
                else if (press[2]) begin m_inc = 1'b1; m_next = M_PAUSE; end
            end else if (m_state == M_RUN) begin
                if (press[0]) m_next = M_PAUSE;
            end else begin
                if (press[1]) begin m_clr = 1'b1; m_next = M_IDLE; end
                else if (press[0]) m_next = M_RUN;
                else if (press[2]) m_inc = 1'b1;
            end
            if (m_next != M_RUN) run_age = 0;
            m_state = m_next;
            m_run   = (m_state == M_RUN);
            // Debounce: level flips once the last DEB samples seen since the
            // previous flip all disagree with it.
            for (int b = 0; b < 3; b++) begin
                seen    = pipe[b][1];
                pipe[b] = {pipe[b][0], raw[b]};
                hist[b] = {hist[b][14:0], seen};
                if (hist_len[b] < 16) hist_len[b]++;
                press[b] = 1'b0;
                want = lvl[b] ? {DEB{1'b0}} : {DEB{1'b1}};
                if (hist_len[b] >= DEB && hist[b][DEB-1:0] == want) begin
                    lvl[b]      = ~lvl[b];
                    hist[b]     = '0;
                    hist_len[b] = 0;
                    press[b]    = lvl[b];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int tests = 0, fails = 0, cyc = 0;
    int en_cnt = 0, inc_cnt = 0, clr_cnt = 0, run_cnt = 0;
    int rise_cyc = 0;
    logic lat_pending = 1'b0, run_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: sample on the falling edge and compare to the model.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        check("en", {31'd0, EN}, {31'd0, m_en});
        check("inc", {31'd0, INC}, {31'd0, m_inc});
        check("clr", {31'd0, CLR}, {31'd0, m_clr});
        check("run", {31'd0, RUN}, {31'd0, m_run});
        check("strobe_excl", {31'd0, (EN & INC) | (EN & CLR) | (INC & CLR)}, 32'd0);
        en_cnt  += int'(EN);
        inc_cnt += int'(INC);
        clr_cnt += int'(CLR);
        run_cnt += int'(RUN);
        if (RUN && !run_prev) begin
            rise_cyc    = cyc;
            lat_pending = 1'b1;
        end
        if (EN && lat_pending) begin
            check("first_en_latency", cyc - rise_cyc, TICK_DIV);
            lat_pending = 1'b0;
        end
        if (!RUN) lat_pending = 1'b0;
        run_prev = RUN;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_btns(input logic [2:0] m);
        BTN_SS  = m[0];
        BTN_CLR = m[1];
        BTN_INC = m[2];
    endtask

    task automatic press_btn(input logic [2:0] m, input int hold);
        set_btns(m);
        repeat (hold) tick();
        set_btns(3'b000);
        repeat (10) tick();
    endtask

    // ---------------- directed + random sequence ----------------
    int s_en, s_inc, s_clr, s_run;

    task automatic snap();
        s_en = en_cnt; s_inc = inc_cnt; s_clr = clr_cnt; s_run = run_cnt;
    endtask

    initial begin
        // Reset
        RST = 1'b1;
        repeat (3) tick();
        check("reset_run", {31'd0, RUN}, 32'd0);
        RST = 1'b0;
        repeat (3) tick();

        // Start: SS held 20 cycles -> RUN with EN cadence, no INC/CLR
        snap();
        press_btn(B_SS, 20);
        repeat (12) tick();
        check("p1_run", {31'd0, RUN}, 32'd1);
        check("p1_en_seen", {31'd0, (en_cnt - s_en) >= 3}, 32'd1);
        check("p1_no_inc", inc_cnt - s_inc, 0);
        check("p1_no_clr", clr_cnt - s_clr, 0);

        // Pause, EN stops; resume restarts a full period
        press_btn(B_SS, 8);
        check("p2_paused", {31'd0, RUN}, 32'd0);
        snap();
        repeat (15) tick();
        check("p2_no_en_paused", en_cnt - s_en, 0);
        press_btn(B_SS, 8);
        repeat (12) tick();
        check("p2_resumed", {31'd0, RUN}, 32'd1);

        // CLR / INC ignored while running
        snap();
        press_btn(B_CLR, 8);
        press_btn(B_INC, 8);
        check("p3_no_clr_in_run", clr_cnt - s_clr, 0);
        check("p3_no_inc_in_run", inc_cnt - s_inc, 0);
        check("p3_still_run", {31'd0, RUN}, 32'd1);

        // Pause then clear -> IDLE
        press_btn(B_SS, 8);
        snap();
        press_btn(B_CLR, 8);
        check("p4_clr_pause", clr_cnt - s_clr, 1);

        // From IDLE: bouncy INC -> exactly one INC, state PAUSE
        snap();
        set_btns(B_INC);
        repeat ($urandom_range(1, DEB - 1)) tick();
        set_btns(3'b000);
        tick();
        set_btns(B_INC);
        repeat (10) tick();
        set_btns(3'b000);
        repeat (10) tick();
        check("p4_one_inc", inc_cnt - s_inc, 1);
        check("p4_not_run", {31'd0, RUN}, 32'd0);
        snap();
        press_btn(B_CLR, 10);
        check("p4_one_clr", clr_cnt - s_clr, 1);

        // PAUSE with CLR and SS on the same edge -> CLR wins, RUN stays 0
        press_btn(B_INC, 8);
        snap();
        press_btn(B_SS | B_CLR, 8);
        check("p5_clr_wins", clr_cnt - s_clr, 1);
        check("p5_run_never", run_cnt - s_run, 0);

        // RST mid-RUN during an INC bounce
        press_btn(B_SS, 8);
        repeat (7) tick();
        set_btns(B_INC);
        repeat (2) tick();
        RST = 1'b1;
        set_btns(3'b000);
        tick();
        check("p6_rst_run", {31'd0, RUN}, 32'd0);
        check("p6_rst_en", {31'd0, EN}, 32'd0);
        RST = 1'b0;
        snap();
        repeat (15) tick();
        check("p6_no_stray_inc", inc_cnt - s_inc, 0);
        press_btn(B_INC, 6);
        check("p6_inc_after_rst", inc_cnt - s_inc, 1);

        // Button held through reset produces one press afterwards
        set_btns(B_SS);
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        snap();
        repeat (8) tick();
        set_btns(3'b000);
        repeat (10) tick();
        check("p7_held_thru_rst", {31'd0, RUN}, 32'd1);

        // Randomised button activity, occasional reset
        repeat (250) begin
            RST = ($urandom_range(0, 39) == 0);
            set_btns(3'($urandom_range(0, 7)));
            repeat ($urandom_range(1, 12)) tick();
            RST = 1'b0;
        end
        set_btns(3'b000);
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control front-end for the stopwatch.
- Conditions three raw push-buttons (synchronise, debounce, edge-detect) and runs the IDLE/RUN/PAUSE state machine.
- Generates the 1/100 s time-base.
- Drives the single-cycle CLR, EN and INC strobes consumed by the BCD centisecond/second counter chain directly downstream.

Parameters:
TICK_DIV, 500000, CLK cycles per EN tick (50 MHz -> 100 Hz); legal range >= 2
DEB_CYCLES, 250000, consecutive stable cycles needed before a debounced level changes (5 ms at 50 MHz); legal range >= 1

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-high
BTN_SS  input  1  raw start/stop button, active-high, asynchronous
BTN_CLR  input  1  raw clear button, active-high, asynchronous
BTN_INC  input  1  raw manual-increment button, active-high, asynchronous
EN  output  1  count-enable tick to counter chain, 1-cycle pulse
INC  output  1  manual increment to counter chain, 1-cycle pulse
CLR  output  1  clear to counter chain, 1-cycle pulse
RUN  output  1  level, high while state == RUN (LED)

Behaviour:
- Reset: every flop is cleared. State = IDLE, all sync/debounce/edge registers = 0, prescaler = 0. EN = INC = CLR = RUN = 0.
- Per button:
  - 2-FF synchroniser.
  - Debouncer holds level D and counter C (width clog2(DEB_CYCLES+1)).
  - Sync output == D -> C = 0.
  - Sync output != D -> C increments. When C reaches DEB_CYCLES-1 while still differing, D toggles and C = 0.
  - Press pulse P = D & ~D_prev, high for exactly 1 cycle per debounced press. Releases generate nothing.
  - Raw input held high from edge t -> D rises at edge t+1+DEB_CYCLES, P high during the following cycle.
  - Glitches shorter than DEB_CYCLES cycles are ignored.
- FSM (registered outputs, decisions taken on P values). Simultaneous-press priority: CLR > SS > INC; lower-priority presses in the same cycle are dropped.
  - IDLE:
    - P_SS -> RUN.
    - P_CLR -> CLR=1 next cycle, stay IDLE.
    - P_INC -> INC=1 next cycle, go PAUSE.
  - RUN:
    - P_SS -> PAUSE.
    - P_CLR and P_INC are ignored (no strobe).
  - PAUSE:
    - P_SS -> RUN.
    - P_CLR -> CLR=1 next cycle, go IDLE.
    - P_INC -> INC=1 next cycle, stay PAUSE.
- RUN output = (state == RUN), registered.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while state == RUN.
  - Forced to 0 in IDLE/PAUSE and on the transition out of RUN.
  - EN = 1 for one cycle when the prescaler wraps from TICK_DIV-1 to 0 in RUN. First EN occurs exactly TICK_DIV cycles after RUN rises.
  - Pausing discards the partial period; resume restarts a full period.
- RUN -> PAUSE on the same cycle the prescaler wraps: the FSM transition takes effect and EN is still issued for that wrap.
- EN, INC and CLR are mutually exclusive in any cycle. At most one strobe per press.
- RST mid-operation: immediate return to reset state on the next edge, regardless of FSM or debounce state. A button held through reset re-debounces and produces one press after release of RST.

Decomposition:
- Package stopwatch_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - Default constants TICK_DIV_DEF and DEB_CYCLES_DEF.
- Sub-module btn_debounce (parameter DEB_CYCLES; ports CLK, RST, BTN_RAW, LEVEL, PRESS): synchroniser, debouncer and edge detector. Instantiated three times.
- FSM and prescaler live in stopwatch_ctrl.

Test Plan (TICK_DIV=5, DEB_CYCLES=4):
- Reset, then BTN_SS held 20 cycles -> one press; RUN=1; EN pulses every 5 cycles, first exactly 5 cycles after RUN rises; INC=CLR=0.
- In RUN, second SS press -> RUN=0, EN stops. Resume -> next EN exactly 5 cycles after RUN re-rises.
- From IDLE, BTN_INC pulsed 2 cycles (bounce) then held 10 cycles -> exactly one INC pulse; state PAUSE. Then BTN_CLR held 10 cycles -> exactly one CLR pulse; state IDLE.
- In RUN, BTN_CLR and BTN_INC presses -> no CLR/INC strobes; EN cadence unaffected.
- In PAUSE, BTN_CLR and BTN_SS rise on the same edge -> CLR pulse, state IDLE, RUN stays 0.
- RST asserted 1 cycle mid-RUN while BTN_INC bounce is in progress -> all outputs 0 and state IDLE next cycle; no stray INC after RST deasserts unless the button is held ≥ 4 stable cycles.
